// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_np register file slice.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;
    localparam int NUM_RD    = 2;

    // Registers and pending bits clear to this bit value on reset.
    localparam logic RST_BIT = 1'b0;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_np_if.sv
// Write, claim and dual read-port bundle for regfile_np.
interface regfile_np_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = addr_w(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic             rd_en1;
    logic             rd_en2;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             busy1;
    logic             busy2;

    modport master (
        output wr_en, wr_addr, wr_data, claim_en, claim_addr,
               rd_en1, rd_en2, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, busy1, busy2
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, claim_en, claim_addr,
               rd_en1, rd_en2, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, busy1, busy2
    );

endinterface

// File: rtl/regfile_np_scoreboard.sv
// Per-register pending bits: claim sets, write clears, claim wins on a tie.
// REGFILE_BYPASS_EN: a same-cycle write is reflected in the busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       claim_en,
    input  logic [AW-1:0]              claim_addr,
    input  logic                       clr_en,
    input  logic [AW-1:0]              clr_addr,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD-1:0][AW-1:0]  rd_addr,
    output logic [NUM_RD-1:0]          busy
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (claim_en) set_vec[claim_addr] = 1'b1;
        if (clr_en)   clr_vec[clr_addr]   = 1'b1;
        if (ZERO_REG != 0) begin
            set_vec[0] = 1'b0;
            clr_vec[0] = 1'b0;
        end
    end

    // Set is OR-ed after the clear so a same-address claim keeps the bit high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= {DEPTH{RST_BIT}};
        else      pending <= (pending & ~clr_vec) | set_vec;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
        always_comb begin
            busy[p] = 1'b0;
            if (rd_en[p] && !((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
                busy[p] = pending[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                if (clr_vec[rd_addr[p]]) busy[p] = set_vec[rd_addr[p]];
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_np.sv
// DEPTH x WIDTH register file, two combinational read ports, one write port,
// optional zero register and pending scoreboard. Macro: REGFILE_BYPASS_EN.
module regfile_np
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_np_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            busy;
    logic                         wr_ok;

    assign rd_en   = {bus.rd_en2, bus.rd_en1};
    assign rd_addr = {bus.rd_addr2, bus.rd_addr1};

    assign bus.rd_data1 = rd_data[0];
    assign bus.rd_data2 = rd_data[1];
    assign bus.busy1    = busy[0];
    assign bus.busy2    = busy[1];

    // Entry 0 is never written when hardwired, so it keeps its reset zero.
    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {WIDTH{RST_BIT}};
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            if (rd_en[p]) begin
                rd_data[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_addr == rd_addr[p])) rd_data[p] = bus.wr_data;
`endif
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (bus.claim_en),
        .claim_addr (bus.claim_addr),
        .clr_en     (bus.wr_en),
        .clr_addr   (bus.wr_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .busy       (busy)
    );

endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-ported register file that generalises the fixed 4-bit storage register into a DEPTH × WIDTH array with two independent read ports, one write port, an optional hardwired zero register and a per-register pending scoreboard. Sits in the ID stage of the 5-stage pipeline. Read ports feed operand fetch. The write port is driven from WB. The scoreboard tells hazard logic which source registers still await an in-flight producer.

## Interface
- WIDTH, 16, data bits per register
- DEPTH, 16, number of registers, power of two, ≥2
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes/claims
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  log2(DEPTH)  write register index
- wr_data  in  WIDTH  write data
- claim_en  in  1  mark claim_addr pending (instruction issued with that destination)
- claim_addr  in  log2(DEPTH)  register to mark pending
- rd_en1 / rd_en2  in  1  read enable, port 1 / 2
- rd_addr1 / rd_addr2  in  log2(DEPTH)  read index, port 1 / 2
- rd_data1 / rd_data2  out  WIDTH  read data, port 1 / 2
- busy1 / busy2  out  1  pending bit of rd_addr1 / rd_addr2

## Operation
- Storage: DEPTH registers of WIDTH bits. Written on the rising clk edge when wr_en=1.
- Reads are combinational. rd_dataN = reg[rd_addrN] when rd_enN=1. Otherwise 0; ports are never tristated.
- Scoreboard: one pending bit per register.
  - claim_en sets pending[claim_addr] at the edge.
  - wr_en clears pending[wr_addr] at the edge.
  - Claim and write to the same address in the same cycle leave pending=1, because the newer producer wins. The data write still happens.
  - Claim and write to different addresses are both applied.
- busyN = pending[rd_addrN] when rd_enN=1, else 0.
- ZERO_REG=1:
  - Writes to index 0 are dropped.
  - Claims to index 0 are dropped.
  - Reads of index 0 return 0 with busy 0.
- Re-claiming an already pending register is legal; the bit stays 1.
- Writing a non-pending register is legal and leaves it 0.
- Both read ports may address the same register, including the write target, with no priority conflict.

## Timing
- Reset (rst=0, asynchronous): all registers 0 and all pending bits 0. Outputs follow combinationally: rd_data 0, busy 0.
- Reset asserted mid-operation discards the pending write and claim of that cycle.
- First write is accepted at the first rising edge after rst deasserts.
- Write latency: data is visible on read ports the cycle after the write edge (bypass off) or in the same cycle (bypass on).
- Claim latency: busy rises the cycle after claim_en.
- No handshake; every strobe is accepted every cycle. There is no stall output.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined:
  - When wr_en=1 and wr_addr==rd_addrN (and not the zero register), rd_dataN = wr_data combinationally in the same cycle.
  - busyN = 0 in that cycle unless claim_en targets the same address.
  - This is write-before-read, and it removes the WB→ID hazard.
- Undefined: reads return the stored value only. A read of the register being written returns the old value until the next cycle. busy reflects the registered pending bit.

## Structure
- Package regfile_pkg: default WIDTH/DEPTH constants, addr-width function (clog2), reset value constant (all zeros).
- Sub-module regfile_scoreboard: DEPTH pending bits with claim/clear inputs, the same-cycle claim-wins rule and the zero-register mask. Two combinational lookup outputs.
- Data array and read muxes stay in the top-level regfile_np.

## Test plan
- Reset, then read all 16 registers on both ports → every rd_data = 0x0000, busy = 0. Assert rst mid-write of 0xBEEF to r5 → r5 stays 0.
- Write 0x1234 to r3, then read r3 on port 1 and r3 on port 2 next cycle → both return 0x1234. With REGFILE_BYPASS_EN, a same-cycle read also returns 0x1234; without it, the same-cycle read returns 0x0000.
- Write 0xFFFF to r0 with claim to r0, ZERO_REG=1 → read r0 = 0x0000, busy = 0. With ZERO_REG=0 → reads 0xFFFF.
- Claim r7, wait 2 cycles → busy1 = 1 for rd_addr1 = 7. Write 0x00AA to r7 → busy clears the next cycle (same cycle with bypass) and data reads 0x00AA.
- Same-cycle claim r9 and write 0x5555 to r9 → r9 = 0x5555 with busy = 1. A later write of 0x6666 clears busy.
- Read with rd_en1 = 0 on a written, pending register → rd_data1 = 0, busy1 = 0. Port 2 is unaffected.
